// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: data width default, canonical NOP and the
// major opcodes that main_decoder also keys on.
package fetch_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  // ADDI x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_RTYPE = 7'b0110011;
  localparam opcode_t OP_ITYPE = 7'b0010011;
  localparam opcode_t OP_LOAD  = 7'b0000011;
  localparam opcode_t OP_STORE = 7'b0100011;

  function automatic opcode_t opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {instr, pc} entries between the memory
// response channel and decode. Flush empties it in one edge and wins over
// push/pop; callers never pop when empty or push when full.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer and occupancy tracking; flush restarts both pointers at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to
// instruction memory, buffers in-order responses and hands them to decode.
//
// Handshakes: every channel is valid/ready; a transfer happens on a rising
// edge where both are 1. Valid never depends on ready of the same channel,
// and request address stays stable while valid waits for ready.
//
// Credit: a request is only issued while (inflight + count) < DEPTH, so each
// response is guaranteed a FIFO slot. On redirect the PC restarts, the FIFO
// is flushed and every still-outstanding response is marked for dropping.
module fetch_stage #(
  parameter int              XLEN      = fetch_stage_pkg::XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              DEPTH     = 4,
  parameter logic [31:0]     NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode
);

  import fetch_stage_pkg::*;

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    resp_pc;
  logic [XLEN-1:0]    target_pc;
  logic [CW-1:0]      count;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      inflight_next;
  logic [CW-1:0]      drop;
  logic [CW:0]        credit_used;
  logic               req_fire;
  logic               resp_take;
  logic               push;
  logic               pop;
  logic [XLEN+31:0]   head;

  assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign credit_used = {1'b0, inflight} + {1'b0, count};

  // Reset gating keeps the request quiet while rst is held.
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding (e.g. a late one from before reset)
  // is ignored so inflight can never underflow.
  assign resp_take      = imem_resp_valid && (inflight != '0);
  assign inflight_next  = inflight + CW'(req_fire) - CW'(resp_take);

  assign push = resp_take && (drop == '0) && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  // PC, response PC and credit/drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        pc      <= target_pc;
        resp_pc <= target_pc;
        drop    <= inflight_next;
      end else begin
        if (req_fire)                     pc      <= pc + XLEN'(4);
        if (push)                         resp_pc <= resp_pc + XLEN'(4);
        if (resp_take && (drop != '0))    drop    <= drop - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_resp_data, resp_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign id_valid  = (count != '0);
  assign id_instr  = id_valid ? head[XLEN+31:XLEN] : NOP_INSTR;
  // When empty, show the PC the next buffered instruction will carry.
  assign id_pc     = id_valid ? head[XLEN-1:0] : resp_pc;
  assign id_opcode = opcode_of(id_instr);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder plus an in-order instruction
// stream model compared against the DUT every cycle.
module tb_fetch_stage;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;

  // clock
  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_opcode(id_opcode)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
    bit          orphan;
  } mem_req_t;

  mem_req_t    mem_q[$];      // accepted, not yet answered requests
  logic [63:0] exp_q[$];      // expected decode queue {pc, instr}
  logic [31:0] acc_log[$];    // accepted request addresses
  logic [31:0] pop_log[$];    // pcs consumed by decode

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  logic [31:0] m_pc = RESET_PC;

  // stimulus knobs
  bit          rst_req = 1'b1;
  bit          redir_req = 1'b0;
  logic [31:0] redir_pc = '0;
  int          ready_pct = 100;
  int          idready_pct = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit has_orphan();
    foreach (mem_q[i]) if (mem_q[i].orphan) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int live_inflight();
    int n = 0;
    foreach (mem_q[i]) if (!mem_q[i].orphan) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock cycle: drive, compare against model, advance model
  task automatic step();
    bit          resp_now;
    bit          exp_rv;
    bit          popv;
    logic [63:0] hd;
    mem_req_t    h;
    int          due;
    @(posedge clk);
    #1;
    rst = rst_req;
    if (rst_req) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].orphan = 1'b1;
      m_pc = RESET_PC;
      epoch++;
    end
    redirect_valid = redir_req && !rst_req;
    redirect_pc    = redir_pc;
    imem_req_ready = has_orphan() ? 1'b0 : ($urandom_range(99) < ready_pct);
    id_ready       = ($urandom_range(99) < idready_pct);
    resp_now       = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(mem_q[0].addr) : $urandom;

    @(negedge clk);
    exp_rv = !rst && !redirect_valid && (live_inflight() + exp_q.size() < DEPTH);
    hd = (exp_q.size() != 0) ? exp_q[0] : {32'h0, NOP};
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, m_pc);
    check("id_valid", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
    check("id_instr", id_instr, hd[31:0]);
    check("id_opcode", {25'b0, id_opcode}, {25'b0, hd[6:0]});
    if (exp_q.size() != 0) check("id_pc", id_pc, hd[63:32]);

    if (!rst) begin
      popv = (exp_q.size() != 0) && id_ready && !redirect_valid;
      if (popv) begin
        pop_log.push_back(exp_q[0][63:32]);
        void'(exp_q.pop_front());
      end
      if (resp_now) begin
        h = mem_q.pop_front();
        if (!h.orphan && h.epoch == epoch && !redirect_valid)
          exp_q.push_back({h.addr, mem_word(h.addr)});
      end
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        m_pc = {redir_pc[31:2], 2'b00};
      end else if (exp_rv && imem_req_ready) begin
        acc_log.push_back(m_pc);
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: m_pc, due: due, epoch: epoch, orphan: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end else if (resp_now) begin
      void'(mem_q.pop_front());
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    repeat (n) step();
    rst_req = 1'b0;
    acc_log.delete();
    pop_log.delete();
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_rst_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_rst_id_valid"}, {31'b0, id_valid}, 32'd0);
    check({tag, "_rst_id_instr"}, id_instr, NOP);
    check({tag, "_rst_id_pc"}, id_pc, RESET_PC);
    check({tag, "_rst_opcode"}, {25'b0, id_opcode}, 32'h13);
  endtask

  initial begin
    int n;
    // reset state
    do_reset(2);
    reset_outputs_check("init");

    // A: 1-cycle memory, decode always ready
    step();
    check("A_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("A_first_req_addr", imem_req_addr, 32'h0);
    step();
    check("A_no_bypass", {31'b0, id_valid}, 32'd0);
    step();
    check("A_first_valid", {31'b0, id_valid}, 32'd1);
    check("A_first_pc", id_pc, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("A_stream_valid", {31'b0, id_valid}, 32'd1);
      check("A_stream_pc", id_pc, 32'(4 * i));
    end

    // B: decode stalled, memory always ready
    do_reset(1);
    idready_pct = 0;
    repeat (10) step();
    check("B_accepted", 32'(acc_log.size()), 32'd4);
    check("B_last_addr", acc_log[3], 32'hC);
    check("B_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    idready_pct = 100;
    repeat (10) step();
    check("B_resume_addr", acc_log[4], 32'h10);
    for (int i = 0; i < 5; i++) check("B_pop_order", pop_log[i], 32'(4 * i));

    // C: memory refuses requests for 3 cycles
    do_reset(1);
    step();
    step();
    ready_pct = 0;
    repeat (3) begin
      step();
      check("C_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("C_hold_addr", imem_req_addr, 32'h8);
    end
    ready_pct = 100;
    step();
    check("C_resumed_addr", acc_log[2], 32'h8);

    // D: redirect with 2 requests in flight and 1 buffered
    do_reset(1);
    idready_pct = 0;
    lat_lo = 3; lat_hi = 3;
    step();
    lat_lo = 5; lat_hi = 5;
    step();
    step();
    ready_pct = 0;
    step();
    redir_req = 1'b1;
    redir_pc  = 32'h0000_0103;
    step();
    check("D_buffered_before", id_pc, 32'h0);
    check("D_no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
    redir_req = 1'b0;
    ready_pct = 100;
    idready_pct = 100;
    lat_lo = 3; lat_hi = 3;
    step();
    check("D_target_req", imem_req_addr, 32'h100);
    repeat (12) step();
    check("D_first_pop", pop_log[0], 32'h100);
    check("D_second_pop", pop_log[1], 32'h104);

    // E: redirect coincides with a response and a decode pop
    do_reset(1);
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();
    redir_req = 1'b1;
    redir_pc  = 32'h0000_2000;
    step();
    check("E_valid_at_redirect", {31'b0, id_valid}, 32'd1);
    n = pop_log.size();
    redir_req = 1'b0;
    repeat (8) step();
    check("E_restart_pc", pop_log[n], 32'h2000);
    check("E_next_pc", pop_log[n + 1], 32'h2004);

    // F: reset mid-stream with requests in flight, late responses after reset
    do_reset(1);
    lat_lo = 3; lat_hi = 3;
    repeat (6) step();
    rst_req = 1'b1;
    step();
    reset_outputs_check("F");
    rst_req = 1'b0;
    acc_log.delete();
    pop_log.delete();
    repeat (15) step();
    check("F_restart_addr", acc_log[0], RESET_PC);
    check("F_restart_pop", pop_log[0], RESET_PC);

    // G: randomized traffic with redirects and occasional resets
    do_reset(1);
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        ready_pct   = $urandom_range(2) == 0 ? 30 : ($urandom_range(1) ? 70 : 100);
        idready_pct = $urandom_range(2) == 0 ? 30 : ($urandom_range(1) ? 70 : 100);
      end
      redir_req = ($urandom_range(99) < 4);
      redir_pc  = $urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(3))) : $urandom;
      rst_req   = ($urandom_range(499) == 0);
      step();
    end
    rst_req = 1'b0;
    redir_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
